// File: rtl/video_blit_writer.sv
// Rectangle blit engine for the CPU-side port of the 32 KB video RAM.
// Runs solid fills and forward-order RAM-to-RAM copies of W x H byte
// rectangles from one command. Each row advance adds STRIDE to the row
// start, and all address arithmetic wraps modulo 2^ADDR_W.
module video_blit_writer #(
  parameter int STRIDE = 160,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [7:0]        cmd_width,
  input  logic [7:0]        cmd_height,
  input  logic [7:0]        cmd_color,
  output logic [ADDR_W-1:0] ram_add,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    COPY_RD,
    COPY_WR,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  state_t            state, state_nxt;
  logic              mode_r;
  logic [ADDR_W-1:0] dst_row, src_row;
  logic [7:0]        width_r, height_r, color_r;
  logic [7:0]        col, row;
  logic              accept, zero_size, last_col, last_row, write_cyc;

  assign accept    = cmd_valid && cmd_ready;
  assign zero_size = (cmd_width == 8'd0) || (cmd_height == 8'd0);
  assign last_col  = (col == width_r - 8'd1);
  assign last_row  = (row == height_r - 8'd1);
  assign write_cyc = (state == FILL) || (state == COPY_WR);

  // State register; async reset aborts any running command immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and simulation order cannot change behaviour.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (zero_size)     state_nxt = DONE;
          else if (cmd_mode) state_nxt = COPY_RD;
          else               state_nxt = FILL;
        end
      end
      FILL:    if (last_col && last_row) state_nxt = DONE;
      COPY_RD: state_nxt = COPY_WR;
      COPY_WR: state_nxt = (last_col && last_row) ? DONE : COPY_RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from state and internal registers only; the one
  // exception is copy data, which passes straight from read to write port.
  always_comb begin
    ram_we    = 1'b0;
    ram_add   = '0;
    ram_wdata = 8'd0;
    case (state)
      FILL: begin
        ram_we    = 1'b1;
        ram_add   = dst_row + ADDR_W'(col);
        ram_wdata = color_r;
      end
      COPY_RD: begin
        ram_add = src_row + ADDR_W'(col);
      end
      COPY_WR: begin
        ram_we    = 1'b1;
        ram_add   = dst_row + ADDR_W'(col);
        ram_wdata = ram_rdata;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Command latch and column/row walker; advances after every write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r   <= 1'b0;
      dst_row  <= '0;
      src_row  <= '0;
      width_r  <= 8'd0;
      height_r <= 8'd0;
      color_r  <= 8'd0;
      col      <= 8'd0;
      row      <= 8'd0;
    end else if (accept) begin
      mode_r   <= cmd_mode;
      dst_row  <= cmd_dst;
      src_row  <= cmd_src;
      width_r  <= cmd_width;
      height_r <= cmd_height;
      color_r  <= cmd_color;
      col      <= 8'd0;
      row      <= 8'd0;
    end else if (write_cyc) begin
      if (last_col) begin
        col     <= 8'd0;
        row     <= row + 8'd1;
        dst_row <= dst_row + STRIDE_A;
        src_row <= src_row + STRIDE_A;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_blit_writer.sv
// Bench for video_blit_writer: a synchronous RAM model, a byte-level shadow
// model that predicts every write, and per-cycle strobe checking.
module tb_video_blit_writer;

  localparam int STRIDE = 160;
  localparam int ADDR_W = 15;
  localparam int AMASK  = 32'h7FFF;

  typedef struct {
    logic [ADDR_W-1:0] add;
    logic [7:0]        data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_mode = 1'b0;
  logic [ADDR_W-1:0] cmd_dst = '0;
  logic [ADDR_W-1:0] cmd_src = '0;
  logic [7:0]        cmd_width = 8'd0;
  logic [7:0]        cmd_height = 8'd0;
  logic [7:0]        cmd_color = 8'd0;
  logic [ADDR_W-1:0] ram_add;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic [7:0]        ram_rdata;
  logic              busy;
  logic              done;

  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_add = '0;
  logic [7:0]        pre_data = 8'd0;

  logic [7:0] mem    [0:32767];
  logic [7:0] shadow [0:32767];
  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  video_blit_writer #(.STRIDE(STRIDE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_width(cmd_width),
    .cmd_height(cmd_height), .cmd_color(cmd_color),
    .ram_add(ram_add), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .busy(busy), .done(done)
  );

  // Synchronous video RAM: write on the edge, read data one clock later.
  always @(posedge clk) begin
    if (ram_we)      mem[ram_add] <= ram_wdata;
    else if (pre_we) mem[pre_add] <= pre_data;
    ram_rdata <= mem[ram_add];
  end

  task automatic preload(input int a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_add = ADDR_W'(a); pre_data = d;
    shadow[a] = d;
    @(posedge clk); #1 pre_we = 1'b0;
  endtask

  // Predict the writes of one command in forward row-major order.
  task automatic model_cmd(input bit mode, input int dst, input int src,
                           input int w, input int h, input logic [7:0] color);
    wr_t e;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int a;
        a = (dst + r * STRIDE + c) & AMASK;
        e.add  = ADDR_W'(a);
        e.data = mode ? shadow[(src + r * STRIDE + c) & AMASK] : color;
        shadow[a] = e.data;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_cmd(input bit mode, input int dst, input int src,
                           input int w, input int h, input logic [7:0] color);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = mode;
    cmd_dst = ADDR_W'(dst); cmd_src = ADDR_W'(src);
    cmd_width = 8'(w); cmd_height = 8'(h); cmd_color = color;
    @(posedge clk);
    cyc = 0;
  endtask

  // One cycle sampled at the falling edge: strobes, status and any write.
  task automatic monitor_cycle(input bit exp_we, input bit exp_done, input bit exp_busy);
    wr_t e;
    @(negedge clk);
    cyc++;
    checks++;
    if (ram_we !== exp_we) begin
      errors++;
      $display("FAIL ram_we cycle %0d: got %b expected %b", cyc, ram_we, exp_we);
    end
    checks++;
    if (done !== exp_done) begin
      errors++;
      $display("FAIL done cycle %0d: got %b expected %b", cyc, done, exp_done);
    end
    checks++;
    if (busy !== exp_busy || cmd_ready !== !exp_busy) begin
      errors++;
      $display("FAIL busy/cmd_ready cycle %0d: got %b/%b expected %b/%b",
               cyc, busy, cmd_ready, exp_busy, !exp_busy);
    end
    if (ram_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write cycle %0d: got %h<=%h expected no write", cyc, ram_add, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        if (ram_add !== e.add || ram_wdata !== e.data) begin
          errors++;
          $display("FAIL write cycle %0d: got %h<=%h expected %h<=%h",
                   cyc, ram_add, ram_wdata, e.add, e.data);
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drained: got %0d writes pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Full command: exact write cadence, done the cycle after the last write,
  // cmd_ready back the cycle after done.
  task automatic run_cmd(input string name, input bit mode, input int dst, input int src,
                         input int w, input int h, input logic [7:0] color);
    int total;
    model_cmd(mode, dst, src, w, h, color);
    total = mode ? 2 * w * h : w * h;
    drive_cmd(mode, dst, src, w, h, color);
    #1 cmd_valid = 1'b0;
    for (int n = 1; n <= total; n++)
      monitor_cycle(mode ? (n % 2 == 0) : 1'b1, 1'b0, 1'b1);
    monitor_cycle(1'b0, 1'b1, 1'b1);
    monitor_cycle(1'b0, 1'b0, 1'b0);
    check_drained(name);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (ram_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
        ram_add !== '0 || ram_wdata !== 8'd0) begin
      errors++;
      $display("FAIL reset: got we=%b done=%b busy=%b rdy=%b add=%h wd=%h expected 0 0 0 1 0 0",
               ram_we, done, busy, cmd_ready, ram_add, ram_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    run_cmd("fill_3x2", 1'b0, 'h0010, 0, 3, 2, 8'hAA);
    run_cmd("fill_5x3", 1'b0, 'h1234, 0, 5, 3, 8'h3C);
  endtask

  task automatic test_copy();
    preload('h0100, 8'h11);
    preload('h0101, 8'h22);
    run_cmd("copy_2x1", 1'b1, 'h0200, 'h0100, 2, 1, 8'h00);
    preload('h01A0, 8'h33);
    preload('h01A1, 8'h44);
    run_cmd("copy_2x2", 1'b1, 'h0600, 'h0100, 2, 2, 8'h00);
    // Overlapping forward copy smears the first byte across the row.
    preload('h0300, 8'h5A);
    run_cmd("copy_overlap", 1'b1, 'h0301, 'h0300, 4, 1, 8'h00);
  endtask

  task automatic test_zero_size();
    run_cmd("zero_w", 1'b0, 'h0040, 0, 0, 5, 8'hFF);
    run_cmd("zero_h", 1'b1, 'h0040, 'h0100, 3, 0, 8'hFF);
  endtask

  task automatic test_wrap();
    run_cmd("wrap", 1'b0, 'h7FFF, 0, 2, 1, 8'h5C);
  endtask

  task automatic test_reset_mid_fill();
    model_cmd(1'b0, 'h2000, 0, 4, 4, 8'h77);
    drive_cmd(1'b0, 'h2000, 0, 4, 4, 8'h77);
    #1 cmd_valid = 1'b0;
    monitor_cycle(1'b1, 1'b0, 1'b1);
    monitor_cycle(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: got we=%b busy=%b rdy=%b done=%b expected 0 0 1 0",
               ram_we, busy, cmd_ready, done);
    end
    exp_q.delete();
    repeat (3) monitor_cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) monitor_cycle(1'b0, 1'b0, 1'b0);
    run_cmd("after_reset", 1'b0, 'h2100, 0, 2, 2, 8'hE1);
  endtask

  task automatic test_cmd_while_busy();
    model_cmd(1'b0, 'h0400, 0, 4, 1, 8'h33);
    model_cmd(1'b0, 'h0500, 0, 2, 1, 8'h99);
    drive_cmd(1'b0, 'h0400, 0, 4, 1, 8'h33);
    // Keep cmd_valid high with a different command while the fill runs.
    #1;
    cmd_dst = 15'h0500; cmd_width = 8'd2; cmd_color = 8'h99;
    repeat (4) monitor_cycle(1'b1, 1'b0, 1'b1);
    monitor_cycle(1'b0, 1'b1, 1'b1);
    monitor_cycle(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) monitor_cycle(1'b1, 1'b0, 1'b1);
    monitor_cycle(1'b0, 1'b1, 1'b1);
    monitor_cycle(1'b0, 1'b0, 1'b0);
    check_drained("busy_ignore");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      int w, h, d;
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      d = $urandom_range(0, 32767);
      run_cmd("rand_fill", 1'b0, d, 0, w, h, 8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    foreach (shadow[i]) shadow[i] = 8'h00;
    test_reset();
    test_fill();
    test_copy();
    test_zero_size();
    test_wrap();
    test_reset_mid_fill();
    test_cmd_while_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
